// File: rtl/uart_fifo_ctrl.sv
// 16550 FIFO controller: FCR decode, RX trigger/timeout flags, TX FIFO-to-serializer sequencing.
// All outputs registered; TX reads wait on serializer busy and never overlap (one read in flight).
module uart_fifo_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int CHAR_TO = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fcr_we,
  input  logic [7:0]             fcr_wdata,
  output logic                   fifo_en,
  output logic [1:0]             trig_level,
  output logic                   rx_clr,
  output logic                   tx_clr,
  input  logic [$clog2(DEPTH):0] rx_count,
  input  logic                   rx_push,
  input  logic                   rx_pop,
  input  logic                   char_tick,
  output logic                   rx_trig,
  output logic                   rx_timeout,
  input  logic                   tx_empty,
  output logic                   tx_rd_en,
  input  logic                   tx_rd_valid,
  input  logic [WIDTH-1:0]       tx_rd_data,
  input  logic                   ser_busy,
  output logic                   ser_start,
  output logic [WIDTH-1:0]       ser_data
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(CHAR_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_START,
    S_BUSY
  } tx_state_e;

  logic             fifo_en_q;
  logic [1:0]       trig_level_q;
  logic             rx_clr_q;
  logic             tx_clr_q;
  logic             rx_trig_q;
  logic             rx_timeout_q;
  logic [TW-1:0]    to_cnt_q;
  logic [TW-1:0]    to_cnt_d;
  logic             to_clr;
  logic [CW-1:0]    thr;
  tx_state_e        state_q;
  logic             tx_rd_en_q;
  logic             ser_start_q;
  logic [WIDTH-1:0] ser_data_q;
  logic             unused_fcr;

  assign unused_fcr = ^fcr_wdata[5:3];

  // Toggling the enable flushes both FIFOs, matching 16550 behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_en_q    <= 1'b0;
      trig_level_q <= 2'b00;
      rx_clr_q     <= 1'b0;
      tx_clr_q     <= 1'b0;
    end else begin
      rx_clr_q <= fcr_we && (fcr_wdata[1] || (fcr_wdata[0] != fifo_en_q));
      tx_clr_q <= fcr_we && (fcr_wdata[2] || (fcr_wdata[0] != fifo_en_q));
      if (fcr_we) begin
        fifo_en_q    <= fcr_wdata[0];
        trig_level_q <= fcr_wdata[7:6];
      end
    end
  end

  always_comb begin
    thr = CW'(1);
    case (trig_level_q)
      2'b00:   thr = CW'(1);
      2'b01:   thr = CW'(4);
      2'b10:   thr = CW'(8);
      default: thr = CW'(14);
    endcase
  end

  always_comb begin
    to_clr   = rx_push || rx_pop || rx_clr_q || (rx_count == '0);
    to_cnt_d = to_cnt_q;
    if (to_clr) begin
      to_cnt_d = '0;
    end else if (char_tick && (to_cnt_q != TW'(CHAR_TO))) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  // Timeout flag follows the next count so a clearing event drops it on the very next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q     <= '0;
      rx_trig_q    <= 1'b0;
      rx_timeout_q <= 1'b0;
    end else begin
      to_cnt_q     <= to_cnt_d;
      rx_trig_q    <= fifo_en_q && (rx_count >= thr);
      rx_timeout_q <= fifo_en_q && (rx_count != '0) && (to_cnt_d == TW'(CHAR_TO));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tx_rd_en_q  <= 1'b0;
      ser_start_q <= 1'b0;
      ser_data_q  <= '0;
    end else begin
      tx_rd_en_q  <= 1'b0;
      ser_start_q <= 1'b0;
      if (tx_clr_q) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!tx_empty && !ser_busy) begin
              state_q    <= S_FETCH;
              tx_rd_en_q <= 1'b1;
            end
          end
          S_FETCH: state_q <= S_WAIT;
          S_WAIT: begin
            // Missing read data means the FIFO was flushed under us; abandon the fetch.
            if (tx_rd_valid) begin
              ser_data_q  <= tx_rd_data;
              ser_start_q <= 1'b1;
              state_q     <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_START: state_q <= S_BUSY;
          S_BUSY: begin
            if (ser_busy) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign fifo_en    = fifo_en_q;
  assign trig_level = trig_level_q;
  assign rx_clr     = rx_clr_q;
  assign tx_clr     = tx_clr_q;
  assign rx_trig    = rx_trig_q;
  assign rx_timeout = rx_timeout_q;
  assign tx_rd_en   = tx_rd_en_q;
  assign ser_start  = ser_start_q;
  assign ser_data   = ser_data_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl with a TX FIFO model, serializer model and a byte scoreboard.
module tb_uart_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fcr_we = 1'b0;
  logic [7:0] fcr_wdata = 8'h00;
  logic       fifo_en;
  logic [1:0] trig_level;
  logic       rx_clr;
  logic       tx_clr;
  logic [4:0] rx_count = 5'd0;
  logic       rx_push = 1'b0;
  logic       rx_pop = 1'b0;
  logic       char_tick = 1'b0;
  logic       rx_trig;
  logic       rx_timeout;
  logic       tx_empty = 1'b1;
  logic       tx_rd_en;
  logic       tx_rd_valid = 1'b0;
  logic [7:0] tx_rd_data = 8'h00;
  logic       ser_busy;
  logic       ser_start;
  logic [7:0] ser_data;

  logic       tb_push = 1'b0;
  logic [7:0] tb_push_dat = 8'h00;
  logic [7:0] tx_mem[$];
  int         busy_cnt = 0;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         n_rd = 0;
  int         n_start = 0;
  int         first_rd = -1;
  int         first_start = -1;
  logic [7:0] exp_q[$];

  uart_fifo_ctrl #(.WIDTH(8), .DEPTH(16), .CHAR_TO(4)) dut (
    .clk(clk), .rst(rst), .fcr_we(fcr_we), .fcr_wdata(fcr_wdata),
    .fifo_en(fifo_en), .trig_level(trig_level), .rx_clr(rx_clr), .tx_clr(tx_clr),
    .rx_count(rx_count), .rx_push(rx_push), .rx_pop(rx_pop), .char_tick(char_tick),
    .rx_trig(rx_trig), .rx_timeout(rx_timeout), .tx_empty(tx_empty), .tx_rd_en(tx_rd_en),
    .tx_rd_valid(tx_rd_valid), .tx_rd_data(tx_rd_data), .ser_busy(ser_busy),
    .ser_start(ser_start), .ser_data(ser_data)
  );

  always #5 clk = ~clk;

  // TX FIFO: registered empty flag, read data one cycle after tx_rd_en.
  always @(posedge clk) begin
    tx_rd_valid <= 1'b0;
    if (rst || tx_clr) begin
      tx_mem.delete();
    end else begin
      if (tx_rd_en && tx_mem.size() > 0) begin
        tx_rd_data  <= tx_mem.pop_front();
        tx_rd_valid <= 1'b1;
      end
      if (tb_push) tx_mem.push_back(tb_push_dat);
    end
    tx_empty <= (tx_mem.size() == 0);
  end

  // Serializer: busy for 10 cycles starting the cycle after ser_start.
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (ser_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign ser_busy = (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [7:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (tx_rd_en) begin
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (ser_start) begin
      n_start++;
      if (first_start < 0) first_start = cyc;
      check("start_while_busy", 32'(ser_busy), 32'd0);
      check("start_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ser_data", 32'(ser_data), 32'(e));
      end
    end
  endtask

  task automatic tick();
    char_tick = 1'b1;
    step();
    char_tick = 1'b0;
    step();
  endtask

  task automatic fcr_write(input logic [7:0] d);
    fcr_we    = 1'b1;
    fcr_wdata = d;
    step();
    fcr_we    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fifo_en"}, 32'(fifo_en), 32'd0);
    check({tag, "_trig_level"}, 32'(trig_level), 32'd0);
    check({tag, "_rx_clr"}, 32'(rx_clr), 32'd0);
    check({tag, "_tx_clr"}, 32'(tx_clr), 32'd0);
    check({tag, "_rx_trig"}, 32'(rx_trig), 32'd0);
    check({tag, "_rx_timeout"}, 32'(rx_timeout), 32'd0);
    check({tag, "_tx_rd_en"}, 32'(tx_rd_en), 32'd0);
    check({tag, "_ser_start"}, 32'(ser_start), 32'd0);
    check({tag, "_ser_data"}, 32'(ser_data), 32'd0);
  endtask

  initial begin
    int thr_tab[4];
    int seq[6];
    logic got;
    thr_tab = '{1, 4, 8, 14};
    seq     = '{0, 1, 2, 3, 4, 3};

    // Reset
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // FCR enable: both clears pulse once; repeated write is silent
    fcr_write(8'hC1);
    check("c1_fifo_en", 32'(fifo_en), 32'd1);
    check("c1_trig", 32'(trig_level), 32'd3);
    check("c1_rx_clr", 32'(rx_clr), 32'd1);
    check("c1_tx_clr", 32'(tx_clr), 32'd1);
    step();
    check("c1_rx_clr_end", 32'(rx_clr), 32'd0);
    check("c1_tx_clr_end", 32'(tx_clr), 32'd0);
    fcr_write(8'hC1);
    check("c1b_rx_clr", 32'(rx_clr), 32'd0);
    check("c1b_tx_clr", 32'(tx_clr), 32'd0);

    // Back-to-back RX resets each pulse
    fcr_write(8'hC3);
    check("b2b_rx_clr0", 32'(rx_clr), 32'd1);
    fcr_write(8'hC3);
    check("b2b_rx_clr1", 32'(rx_clr), 32'd1);
    check("b2b_tx_clr1", 32'(tx_clr), 32'd0);
    step();
    check("b2b_rx_clr_end", 32'(rx_clr), 32'd0);

    // Trigger level 01 with the stepped occupancy sequence
    fcr_write(8'h41);
    for (int i = 0; i < 6; i++) begin
      rx_count = 5'(seq[i]);
      step();
      check($sformatf("trig01_cnt%0d_step%0d", seq[i], i), 32'(rx_trig), 32'(seq[i] >= 4));
    end

    // Each trigger threshold boundary
    for (int l = 0; l < 4; l++) begin
      fcr_write({2'(l), 6'b000001});
      rx_count = 5'(thr_tab[l] - 1);
      step();
      check($sformatf("trig%0d_below", l), 32'(rx_trig), 32'd0);
      rx_count = 5'(thr_tab[l]);
      step();
      check($sformatf("trig%0d_at", l), 32'(rx_trig), 32'd1);
    end

    // Character timeout
    rx_count = 5'd0;
    step();
    rx_count = 5'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("to_tick%0d", i + 1), 32'(rx_timeout), 32'(i == 3));
    end
    tick();
    check("to_saturated", 32'(rx_timeout), 32'd1);
    rx_pop = 1'b1;
    step();
    rx_pop = 1'b0;
    check("to_pop_drop", 32'(rx_timeout), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    rx_push = 1'b1;
    step();
    rx_push = 1'b0;
    tick();
    check("to_push_restart", 32'(rx_timeout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("to_after_push%0d", i + 2), 32'(rx_timeout), 32'(i == 2));
    end
    fcr_write(8'h43);
    check("to_rxclr_pulse", 32'(rx_clr), 32'd1);
    check("to_rxclr_no_tx", 32'(tx_clr), 32'd0);
    check("to_rxclr_hold", 32'(rx_timeout), 32'd1);
    step();
    check("to_rxclr_drop", 32'(rx_timeout), 32'd0);
    rx_count = 5'd0;

    // TX sequencing of two bytes
    tb_push     = 1'b1;
    tb_push_dat = 8'hA5;
    exp_q.push_back(8'hA5);
    step();
    tb_push_dat = 8'h3C;
    exp_q.push_back(8'h3C);
    step();
    tb_push = 1'b0;
    check("tx_rd_en_latency", 32'(tx_rd_en), 32'd1);
    step();
    check("tx_rd_en_one_cycle", 32'(tx_rd_en), 32'd0);
    step();
    check("ser_start_latency", 32'(ser_start), 32'd1);
    for (int i = 0; i < 35; i++) step();
    check("tx_starts", 32'(n_start), 32'd2);
    check("tx_reads", 32'(n_rd), 32'd2);
    check("rd_to_start", 32'(first_start - first_rd), 32'd2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("ser_data_held", 32'(ser_data), 32'h3C);

    // Aborted fetch via TX reset
    tb_push     = 1'b1;
    tb_push_dat = 8'h77;
    step();
    tb_push = 1'b0;
    step();
    check("abort_fetch", 32'(tx_rd_en), 32'd1);
    fcr_write(8'h04);
    check("abort_tx_clr", 32'(tx_clr), 32'd1);
    check("abort_rx_clr", 32'(rx_clr), 32'd1);
    check("abort_fifo_en", 32'(fifo_en), 32'd0);
    for (int i = 0; i < 12; i++) step();
    check("abort_starts", 32'(n_start), 32'd2);
    check("abort_reads", 32'(n_rd), 32'd3);
    check("abort_ser_data", 32'(ser_data), 32'h3C);

    // Reset while BUSY
    fcr_write(8'h81);
    rx_count = 5'd9;
    step();
    check("pre_rst_trig", 32'(rx_trig), 32'd1);
    tb_push     = 1'b1;
    tb_push_dat = 8'h5A;
    exp_q.push_back(8'h5A);
    step();
    tb_push = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = ser_start;
    end
    check("busy_start_seen", 32'(got), 32'd1);
    step();
    rst = 1'b1;
    step();
    check_all_zero("busy_rst");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("post_rst_starts", 32'(n_start), 32'd3);
    check("post_rst_no_start", 32'(ser_start), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
- FIFO controller for the 16550 core. Sits between the register file and the two fifo_lite instances (RX and TX).
- Decodes FCR writes into FIFO enable, trigger level and one-cycle clear pulses.
- Generates the RX trigger-level and character-timeout conditions for the interrupt logic.
- Sequences TX FIFO reads into the transmit serializer: handles the FIFO's 1-cycle read latency and the serializer's busy handshake.

Parameters:
- WIDTH, 8, data word width.
- DEPTH, 16, FIFO depth; must be >= 16 so trigger level 14 is reachable.
- CHAR_TO, 4, character times of RX inactivity before timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- fcr_we  in  1  FCR write strobe.
- fcr_wdata  in  8  FCR data: [0] FIFO enable, [1] RX reset, [2] TX reset, [7:6] trigger level.
- fifo_en  out  1  registered FCR[0].
- trig_level  out  2  registered FCR[7:6].
- rx_clr  out  1  one-cycle RX FIFO clear pulse.
- tx_clr  out  1  one-cycle TX FIFO clear pulse.
- rx_count  in  $clog2(DEPTH)+1  RX FIFO occupancy.
- rx_push  in  1  RX FIFO write strobe.
- rx_pop  in  1  RX FIFO read strobe.
- char_tick  in  1  one-cycle pulse per character time, from the baud generator.
- rx_trig  out  1  RX occupancy >= trigger threshold.
- rx_timeout  out  1  RX character timeout.
- tx_empty  in  1  TX FIFO empty.
- tx_rd_en  out  1  TX FIFO read enable.
- tx_rd_valid  in  1  TX FIFO read data valid (1 cycle after tx_rd_en).
- tx_rd_data  in  WIDTH  TX FIFO read data.
- ser_busy  in  1  serializer busy; rises the cycle after ser_start.
- ser_start  out  1  one-cycle start pulse to the serializer.
- ser_data  out  WIDTH  byte for the serializer; valid while ser_start is high and held until the next start.

Behaviour:
- Reset: all outputs 0, trig_level=00, timeout counter 0, TX FSM in IDLE. rst overrides every other input.
- FCR write at edge k:
  - fifo_en and trig_level are updated at k.
  - rx_clr is high for the cycle after k if fcr_wdata[1]=1 or fcr_wdata[0] differs from fifo_en.
  - tx_clr is high for the cycle after k if fcr_wdata[2]=1 or fcr_wdata[0] differs from fifo_en.
  - Back-to-back FCR writes each produce their own pulse.
- Trigger thresholds: 00->1, 01->4, 10->8, 11->14.
  - rx_trig is registered: rx_trig = fifo_en && rx_count >= threshold, sampled one cycle earlier.
- Timeout counter, CHAR_TO-saturating:
  - Cleared on rx_push, rx_pop, rx_clr, or rx_count==0. Clear has priority over increment in the same cycle.
  - Otherwise increments on char_tick.
  - rx_timeout is registered: rx_timeout = fifo_en && rx_count!=0 && counter==CHAR_TO.
  - rx_timeout drops the cycle after any clearing event.
- TX FSM (Moore outputs):
  - IDLE: go to FETCH when !tx_empty && !ser_busy && !tx_clr.
  - FETCH: tx_rd_en=1 for exactly one cycle; go to WAIT.
  - WAIT: on tx_rd_valid capture tx_rd_data into ser_data and go to START. If tx_rd_valid is not seen in this cycle (FIFO cleared), return to IDLE.
  - START: ser_start=1 for one cycle; go to BUSY.
  - BUSY: stay until ser_busy=1, then go to IDLE. IDLE then waits for ser_busy=0.
  - Latency: from tx_empty falling with the serializer idle, tx_rd_en follows 1 cycle later and ser_start 3 cycles later.
  - tx_clr in any state forces IDLE on the next edge; no ser_start is issued for an aborted fetch.
  - ser_data retains its last value.
  - Sequencing is independent of fifo_en.
- Never more than one outstanding FIFO read; tx_rd_en is never asserted while tx_empty=1 was sampled in IDLE.

Test Plan:
- Reset, then FCR write 0xC1 -> fifo_en=1, trig_level=11, rx_clr=1 and tx_clr=1 for exactly one cycle (enable changed); a second 0xC1 write produces no pulses.
- fifo_en=1, trig 01; step rx_count 0,1,2,3,4,3 -> rx_trig goes high one cycle after count=4 and falls one cycle after count=3.
- rx_count=2, no push/pop, 4 char_ticks -> rx_timeout=1 after the 4th tick; a single rx_pop -> rx_timeout=0 next cycle; an additional tick before the 4th, with a push in between, restarts the count.
- TX FIFO holds 0xA5, 0x3C; serializer model raises busy 1 cycle after start for 10 cycles -> ser_start twice with ser_data 0xA5 then 0x3C; tx_rd_en pulses exactly twice; no start while busy.
- FCR write 0x04 while in FETCH -> tx_clr pulse, FSM returns to IDLE, no ser_start, tx_empty=1 keeps it idle.
- rst asserted while in BUSY -> all outputs 0 and IDLE on the next edge; after release, no spurious ser_start.
